// File: rtl/word_to_nibble_serializer.sv
// rtl/word_to_nibble_serializer.sv - serializes a 16-bit word into 1..4 nibbles with ready/valid handshakes
module word_to_nibble_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_word,
  input  logic [1:0]  in_len,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  out_nib,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        trunc_err
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  sel_d;
  logic [3:0]  nib_d;
  logic        in_xfer;
  logic        out_xfer;
  logic        upper_nz;
  logic        trunc_d;

  // out_last is only ever set in SEND, so the handoff term is safe in IDLE too
  assign in_ready = (state_q == IDLE) | (out_ready & out_last);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    if ((state_q == SEND) && out_xfer) begin
      if (out_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
    // A new word overrides the return to IDLE, giving gap-free back-to-back words
    if (in_xfer) begin
      state_d = SEND;
      word_d  = in_word;
      len_d   = in_len;
      idx_d   = 2'd0;
    end
  end

  // Nibble for the next cycle is precomputed so out_nib comes straight from a flop
  always_comb begin
    sel_d = LSB_FIRST ? idx_d : (len_d - idx_d);
    case (sel_d)
      2'd0:    nib_d = word_d[3:0];
      2'd1:    nib_d = word_d[7:4];
      2'd2:    nib_d = word_d[11:8];
      default: nib_d = word_d[15:12];
    endcase
  end

  always_comb begin
    case (in_len)
      2'd0:    upper_nz = |in_word[15:4];
      2'd1:    upper_nz = |in_word[15:8];
      2'd2:    upper_nz = |in_word[15:12];
      default: upper_nz = 1'b0;
    endcase
    trunc_d = in_xfer & upper_nz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= 16'h0000;
      len_q     <= 2'd0;
      idx_q     <= 2'd0;
      out_nib   <= 4'h0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      out_nib   <= (state_d == SEND) ? nib_d : 4'h0;
      out_valid <= (state_d == SEND);
      out_last  <= (state_d == SEND) && (idx_d == len_d);
      trunc_err <= trunc_d;
    end
  end

endmodule
